// File: rtl/sync1100_tx.sv
// sync1100_tx: serial frame transmitter.
// Each accepted word goes out as the sync word 1100, then the payload MSB
// first, an optional even-parity bit, then GAP_BITS forced-0 guard bits.
// The line x, sof and done are registered and loaded from the next-state
// values, so they line up with the state the FSM is about to enter.
// Optional feature: define SYNC1100_TX_PARITY_EN to insert the parity bit.
module sync1100_tx #(
    parameter int DATA_W   = 8,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              valid,
    output logic              ready,
    output logic              x,
    output logic              sof,
    output logic              done
);

    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [3:0]    GAP_LAST  = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SYNC = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] GAP  = 3'd4;
`ifdef SYNC1100_TX_PARITY_EN
    localparam logic [2:0] PAR  = 3'd3;
    localparam logic [2:0] AFTER_DATA = PAR;
    localparam logic [2:0] AFTER_PAR  = (GAP_BITS > 0) ? GAP : IDLE;
`else
    localparam logic [2:0] AFTER_DATA = (GAP_BITS > 0) ? GAP : IDLE;
`endif

    logic [2:0]        state, state_n;
    logic [1:0]        scnt, scnt_n;
    logic [BW-1:0]     bcnt, bcnt_n;
    logic [3:0]        gcnt, gcnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
`ifdef SYNC1100_TX_PARITY_EN
    logic              par, par_n;
`endif
    logic              x_n, sof_n, done_n;

    // Requests are only taken while idle; valid is otherwise ignored.
    assign ready = (state == IDLE);

    // State, counter and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            scnt  <= '0;
            bcnt  <= '0;
            gcnt  <= '0;
            shreg <= '0;
`ifdef SYNC1100_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            scnt  <= scnt_n;
            bcnt  <= bcnt_n;
            gcnt  <= gcnt_n;
            shreg <= shreg_n;
`ifdef SYNC1100_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    // Next-state and counter sequencing; unused encodings fall back to IDLE.
    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bcnt_n  = bcnt;
        gcnt_n  = gcnt;
        shreg_n = shreg;
`ifdef SYNC1100_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                if (valid) begin
                    state_n = SYNC;
                    scnt_n  = '0;
                    bcnt_n  = '0;
                    gcnt_n  = '0;
                    shreg_n = din;
`ifdef SYNC1100_TX_PARITY_EN
                    par_n   = ^din;
`endif
                end
            end
            SYNC: begin
                scnt_n = scnt + 1'b1;
                if (scnt == 2'd3) begin
                    state_n = DATA;
                    bcnt_n  = '0;
                end
            end
            DATA: begin
                if (bcnt == DATA_LAST) begin
                    state_n = AFTER_DATA;
                    gcnt_n  = '0;
                end else begin
                    bcnt_n  = bcnt + 1'b1;
                    shreg_n = shreg << 1;
                end
            end
`ifdef SYNC1100_TX_PARITY_EN
            PAR: begin
                state_n = AFTER_PAR;
                gcnt_n  = '0;
            end
`endif
            GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_n = IDLE;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line value and strobes for the cycle the FSM is entering.
    always_comb begin
        x_n    = 1'b0;
        sof_n  = 1'b0;
        done_n = 1'b0;
        case (state_n)
            SYNC: begin
                x_n   = ~scnt_n[1];
                sof_n = (scnt_n == 2'd0);
            end
            DATA: begin
                x_n    = shreg_n[DATA_W-1];
                done_n = (AFTER_DATA == IDLE) && (bcnt_n == DATA_LAST);
            end
`ifdef SYNC1100_TX_PARITY_EN
            PAR: begin
                x_n    = par_n;
                done_n = (AFTER_PAR == IDLE);
            end
`endif
            GAP: begin
                done_n = (gcnt_n == GAP_LAST);
            end
            default: begin
                x_n    = 1'b0;
                sof_n  = 1'b0;
                done_n = 1'b0;
            end
        endcase
    end

    // Registered serial line and frame strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= 1'b0;
            sof  <= 1'b0;
            done <= 1'b0;
        end else begin
            x    <= x_n;
            sof  <= sof_n;
            done <= done_n;
        end
    end

endmodule

// File: doc/sync1100_tx.md
SYNC1100_TX -- requirements
Module: sync1100_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (legal range 2..32).
REQ-002 SHALL have parameter GAP_BITS, default 2, number of forced-0 guard bits after each frame (legal range 0..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port din  input  DATA_W  payload word to transmit.
REQ-006 SHALL have port valid  input  1  din holds a frame request.
REQ-007 SHALL have port ready  output  1  block can accept a request this cycle.
REQ-008 SHALL have port x  output  1  registered serial line; idle level 0.
REQ-009 SHALL have port sof  output  1  high for exactly the cycle in which x carries the first sync bit.
REQ-010 SHALL have port done  output  1  single-cycle pulse on the last bit of the frame (last gap bit, or last payload/parity bit if GAP_BITS=0).

Function
REQ-011 SHALL implement FSM states IDLE, SYNC, DATA, PAR, GAP.
REQ-012 SHALL assert ready only in IDLE; a request is accepted on a rising clk edge with valid=1 and ready=1.
REQ-013 SHALL capture din into an internal shift register on accept; later din changes have no effect on the frame in flight.
REQ-014 SHALL drive x with the sync word 1,1,0,0 on the 4 cycles after accept (state SYNC, 2-bit counter).
REQ-015 SHALL then drive the payload MSB first for DATA_W cycles (state DATA, bit counter of width ceil(log2(DATA_W))+1).
REQ-016 SHALL go to PAR when PARITY_EN is defined, otherwise directly to GAP (or IDLE when GAP_BITS=0).
REQ-017 SHALL drive x=0 for GAP_BITS cycles in GAP, then return to IDLE with ready=1 on the following cycle.
REQ-018 SHALL drive x=0 in IDLE; sof and done are 0 outside the cycles defined in REQ-009/REQ-010.
REQ-019 SHALL have a request-to-next-ready latency of exactly 4+DATA_W+P+GAP_BITS cycles, where P=1 with PARITY_EN and P=0 without.
REQ-020 SHALL ignore valid whenever ready=0; no request is queued or dropped-with-side-effect.
REQ-021 SHALL accept back-to-back requests when valid is held high: first sync bit of the next frame follows the last gap cycle after one IDLE cycle.
REQ-022 SHALL NOT alter the payload when it contains 1100 (no escaping); rejecting false syncs is the receiver's job.
REQ-023 SHALL fall back to IDLE with x=0 from any unused state encoding.

Reset
REQ-024 SHALL, while rst=1, force state=IDLE, x=0, sof=0, done=0, ready=1, all counters and the shift register to 0, independent of clk.
REQ-025 SHALL abandon any frame in progress on reset assertion; after release the first frame starts only on a new accept.
REQ-026 SHALL NOT accept a request on a clk edge where rst=1.

Configuration
REQ-027 SHALL use macro SYNC1100_TX_PARITY_EN to select the parity feature.
REQ-028 SHALL, with SYNC1100_TX_PARITY_EN defined, emit one even-parity bit (XOR of all payload bits) in state PAR, directly after the payload LSB.
REQ-029 SHALL, with SYNC1100_TX_PARITY_EN undefined, omit state PAR, its logic and its cycle entirely.

Verification
REQ-030 SHALL be covered by these directed scenarios, DATA_W=8 and GAP_BITS=2 unless stated:
- Reset held 3 cycles, valid=0 -> x=0, ready=1, sof=0, done=0 throughout.
- din=8'hA5, valid pulse, no parity -> x=1,1,0,0,1,0,1,0,0,1,0,1,0,0; sof on cycle 1, done on cycle 14; ready=1 on cycle 15; the 1100 Mealy detector output pulses once, on the 4th sync bit.
- Same stimulus with SYNC1100_TX_PARITY_EN -> parity bit 0 inserted after payload; done on cycle 15; ready on cycle 16.
- valid held high, din=8'hFF then 8'h00 -> two complete frames, one IDLE cycle with ready=1 between them; second frame carries 8'h00.
- rst asserted during payload bit 3 of din=8'hC3 -> x=0 immediately; ready=1; no done pulse; next accept restarts with sync 1100.
- GAP_BITS=0, din=8'h0C (contains 1100) -> payload sent unaltered; done on the payload LSB cycle; detector pulses twice (sync and payload).
